// File: rtl/slt_pkg.sv
// Shared definitions for the serial set-less-than unit and its zero-extension consumer.
// Holds the FSM state encoding and the default operand and counter widths.
package slt_pkg;

  localparam int unsigned SLT_WIDTH = 32;
  localparam int unsigned SLT_CNT_W = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } slt_state_e;

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full adder used as the serial bit slice of the subtractor.
module full_adder_1b (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic sum_o,
  output logic cout_o
);

  assign sum_o  = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/slt_serial_comparator.sv
// Bit-serial a - b (LSB first) producing signed/unsigned less-than and equality flags.
// Handshake: start is accepted when busy=0 (IDLE or DONE); done pulses one cycle with lt/eq valid.
module slt_serial_comparator
  import slt_pkg::*;
#(
  parameter int WIDTH = SLT_WIDTH,
  parameter int CNT_W = SLT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic [1:0]       state_o
);

  slt_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             signed_q, signed_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;
  logic             done_q, done_d;

  logic fa_sum;
  logic fa_cout;
  logic last_bit;
  logic accept;

  // Subtraction as a + ~b + 1: the +1 comes from carry being preset at accept.
  full_adder_1b u_fa (
    .a_i    (a_sh_q[0]),
    .b_i    (~b_sh_q[0]),
    .cin_i  (carry_q),
    .sum_o  (fa_sum),
    .cout_o (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
  assign accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    signed_d = signed_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_sh_d   = a;
          b_sh_d   = b;
          signed_d = is_signed;
          carry_d  = 1'b1;
          zero_d   = 1'b1;
          cnt_d    = '0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_RUN: begin
        carry_d = fa_cout;
        zero_d  = zero_q & ~fa_sum;
        a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CNT_W'(1);
        if (last_bit) begin
          // Signed: sign of the difference XOR overflow (carry into MSB vs carry out).
          lt_d    = signed_q ? (fa_sum ^ (carry_q ^ fa_cout)) : ~fa_cout;
          eq_d    = zero_q & ~fa_sum;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      signed_q <= 1'b0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      signed_q <= signed_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
      done_q   <= done_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = done_q;
  assign lt      = lt_q;
  assign eq      = eq_q;
  assign state_o = state_q;

endmodule
